stream_fifo: RTL and testbench



---
 rtl/stream_fifo_pkg.sv | 18 +
 rtl/stream_fifo_if.sv | 35 +++
 rtl/stream_fifo_ptr.sv | 42 ++++
 rtl/stream_fifo.sv | 108 ++++++++++
 tb/tb_stream_fifo.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_pkg
//  Description : Shared helpers for the stream FIFO. Holds the wrapping
//                pointer increment used by the read and write pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_fifo_pkg;

    // Increment a pointer that lives in 0..depth-1 and wraps explicitly, so
    // non-power-of-two depths work without relying on modulo-2^n overflow.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_if
//  Description : Valid/ready stream bundle plus FIFO status. The slave modport
//                is the FIFO side; the master modport is the producer and
//                consumer environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, full, empty
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/stream_fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_ptr
//  Description : Wrapping pointer register (0..DEPTH-1) with an increment
//                enable and asynchronous active-low reset to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo_ptr
    import stream_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     inc,
    output logic [$clog2(DEPTH)-1:0]      ptr
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer: hold, or step with explicit wrap at DEPTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = PW'(next_ptr(32'(ptr_q), DEPTH));
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo
//  Description : Single-clock valid/ready FIFO, first-word-fall-through.
//                Handshake flags depend only on the registered count, so no
//                combinational path exists from in_valid/out_ready to outputs.
//                Optional macro STREAM_FIFO_ASSERT_EN compiles in embedded
//                protocol assertions; logic is identical either way.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    stream_fifo_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // Storage carries no reset: reset only discards entries via the pointers.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          in_ready;
    logic          out_valid;
    logic          push;
    logic          pop;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    stream_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    stream_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Write port: capture in_data only on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = count_q;
    assign bus.full      = (count_q == CW'(DEPTH));
    assign bus.empty     = (count_q == '0);

`ifdef STREAM_FIFO_ASSERT_EN
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CW'(DEPTH));

    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == CW'(DEPTH)) |-> !push);

    a_empty_no_valid : assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == '0) |-> !out_valid);

    a_count_step : assert property (@(posedge clk) disable iff (!rst_n)
        1'b1 |=> ((count_q == $past(count_q)) ||
                  (count_q == $past(count_q) + CW'(1)) ||
                  (count_q == $past(count_q) - CW'(1))));

    a_data_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !bus.out_ready) |=> $stable(bus.out_data));
`else
    // No embedded checks in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_fifo
//  Description : Self-checking bench for stream_fifo. Drives a DEPTH=16 and a
//                DEPTH=5 instance and compares both against queue models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stream_fifo_if #(.WIDTH(32), .DEPTH(16)) b16 ();
    stream_fifo_if #(.WIDTH(32), .DEPTH(5))  b5  ();

    stream_fifo #(.WIDTH(32), .DEPTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    stream_fifo #(.WIDTH(32), .DEPTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(b5));

    logic [31:0] q16 [$];
    logic [31:0] q5  [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue per instance, flushed by reset.
    always @(posedge clk or negedge rst_n) begin
        bit p16, o16, p5, o5;
        if (!rst_n) begin
            q16.delete();
            q5.delete();
        end else begin
            p16 = b16.in_valid && (q16.size() < 16);
            o16 = b16.out_ready && (q16.size() > 0);
            p5  = b5.in_valid && (q5.size() < 5);
            o5  = b5.out_ready && (q5.size() > 0);
            if (o16) void'(q16.pop_front());
            if (p16) q16.push_back(b16.in_data);
            if (o5)  void'(q5.pop_front());
            if (p5)  q5.push_back(b5.in_data);
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("m16_count", 64'(b16.count), 64'(q16.size()));
            check("m16_in_ready", 64'(b16.in_ready), 64'(q16.size() != 16));
            check("m16_out_valid", 64'(b16.out_valid), 64'(q16.size() != 0));
            check("m16_full", 64'(b16.full), 64'(q16.size() == 16));
            check("m16_empty", 64'(b16.empty), 64'(q16.size() == 0));
            if (q16.size() > 0) check("m16_data", 64'(b16.out_data), 64'(q16[0]));
            check("m5_count", 64'(b5.count), 64'(q5.size()));
            check("m5_in_ready", 64'(b5.in_ready), 64'(q5.size() != 5));
            check("m5_out_valid", 64'(b5.out_valid), 64'(q5.size() != 0));
            check("m5_full", 64'(b5.full), 64'(q5.size() == 5));
            check("m5_empty", 64'(b5.empty), 64'(q5.size() == 0));
            if (q5.size() > 0) check("m5_data", 64'(b5.out_data), 64'(q5[0]));
        end
    end

    initial begin
        b16.in_valid = 1'b0; b16.in_data = '0; b16.out_ready = 1'b0;
        b5.in_valid  = 1'b0; b5.in_data  = '0; b5.out_ready  = 1'b0;

        // Reset state.
        repeat (3) cyc();
        rst_n = 1'b1;
        check("rst_count", 64'(b16.count), 64'd0);
        check("rst_in_ready", 64'(b16.in_ready), 64'd1);
        check("rst_out_valid", 64'(b16.out_valid), 64'd0);
        check("rst_empty", 64'(b16.empty), 64'd1);
        check("rst_full", 64'(b16.full), 64'd0);

        // Single push, visible one cycle later.
        b16.in_valid = 1'b1; b16.in_data = 32'hA5A5_0001;
        cyc();
        b16.in_valid = 1'b0;
        check("one_out_valid", 64'(b16.out_valid), 64'd1);
        check("one_out_data", 64'(b16.out_data), 64'hA5A5_0001);
        check("one_count", 64'(b16.count), 64'd1);
        check("one_empty", 64'(b16.empty), 64'd0);
        b16.out_ready = 1'b1;
        cyc();
        b16.out_ready = 1'b0;
        check("one_drained", 64'(b16.empty), 64'd1);

        // Fill to full, then offer a 17th word.
        for (int i = 0; i < 16; i++) begin
            b16.in_valid = 1'b1; b16.in_data = 32'(i);
            cyc();
        end
        check("full_count", 64'(b16.count), 64'd16);
        check("full_flag", 64'(b16.full), 64'd1);
        check("full_in_ready", 64'(b16.in_ready), 64'd0);
        b16.in_data = 32'h99;
        cyc();
        b16.in_valid = 1'b0;
        check("full_ignored", 64'(b16.count), 64'd16);

        // Drain in order.
        b16.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 64'(b16.out_data), 64'(i));
            cyc();
        end
        b16.out_ready = 1'b0;
        check("drain_empty", 64'(b16.empty), 64'd1);
        check("drain_out_valid", 64'(b16.out_valid), 64'd0);

        // Steady-state streaming at occupancy 5 across pointer wraps.
        for (int i = 0; i < 5; i++) begin
            b16.in_valid = 1'b1; b16.in_data = 32'(100 + i);
            cyc();
        end
        b16.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            b16.in_data = 32'(105 + k);
            check("stream_head", 64'(b16.out_data), 64'(100 + k));
            check("stream_count", 64'(b16.count), 64'd5);
            cyc();
        end
        b16.out_ready = 1'b0;
        check("stream_end_head", 64'(b16.out_data), 64'd140);

        // Mid-stream asynchronous reset at count 7.
        b16.in_data = 32'd200; cyc();
        b16.in_data = 32'd201; cyc();
        b16.in_valid = 1'b0;
        check("pre_rst_count", 64'(b16.count), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 64'(b16.count), 64'd0);
        check("arst_out_valid", 64'(b16.out_valid), 64'd0);
        check("arst_in_ready", 64'(b16.in_ready), 64'd1);
        rst_n = 1'b1;
        cyc();
        b16.in_valid = 1'b1; b16.in_data = 32'h0000_BEEF;
        cyc();
        b16.in_valid = 1'b0;
        check("post_rst_data", 64'(b16.out_data), 64'h0000_BEEF);
        check("post_rst_count", 64'(b16.count), 64'd1);

        // DEPTH=5 instance: fill to full, then random traffic.
        for (int i = 0; i < 6; i++) begin
            b5.in_valid = 1'b1; b5.in_data = 32'(8'h50 + i);
            cyc();
        end
        b5.in_valid = 1'b0;
        check("d5_full_count", 64'(b5.count), 64'd5);
        check("d5_full_flag", 64'(b5.full), 64'd1);
        check("d5_head", 64'(b5.out_data), 64'h50);
        for (int n = 0; n < 1000; n++) begin
            b5.in_valid  = 1'($urandom_range(0, 1));
            b5.out_ready = 1'($urandom_range(0, 1));
            b5.in_data   = $urandom;
            cyc();
        end
        b5.in_valid = 1'b0; b5.out_ready = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
